// File: rtl/fht_result_reader.sv
// fht_result_reader: drains the four-bank FHT result RAM row by row and
// re-emits it as a serial valid/ready stream, two-row prefetch buffer.
// Ports: iCLK, iRESET (async, low), iSTART, iABORT, oADDR_RD,
//   iBANK_0..3, oDATA, oINDEX, oVALID, iREADY, oLAST, oBUSY, oDONE.
module fht_result_reader #(
  parameter int D_BIT  = 17,
  parameter int A_BIT  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  input  logic             iABORT,
  output logic [A_BIT-1:0] oADDR_RD,
  input  logic [D_BIT-1:0] iBANK_0,
  input  logic [D_BIT-1:0] iBANK_1,
  input  logic [D_BIT-1:0] iBANK_2,
  input  logic [D_BIT-1:0] iBANK_3,
  output logic [D_BIT-1:0] oDATA,
  output logic [A_BIT+1:0] oINDEX,
  output logic             oVALID,
  input  logic             iREADY,
  output logic             oLAST,
  output logic             oBUSY,
  output logic             oDONE
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [A_BIT-1:0] ROW_MAX = '1;

  logic [1:0]        state;
  logic [RD_LAT-1:0] tags;
  logic [D_BIT-1:0]  slot [2][4];
  logic              head;
  logic              tail;
  logic [1:0]        buf_cnt;
  logic [1:0]        lane;
  logic [A_BIT-1:0]  out_row;
  logic              done_q;

  logic [2:0] occupancy;
  logic       issue;
  logic       capture;
  logic       hs;
  logic       pop;
  logic       last_word;

  // Rows buffered plus rows still travelling through the RAM latency.
  assign occupancy = 3'(buf_cnt) + 3'($countones(tags));
  assign issue     = (state == S_RUN) && (occupancy < 3'd2) && !iABORT;
  assign capture   = tags[RD_LAT-1];
  assign hs        = oVALID && iREADY;
  assign pop       = hs && (lane == 2'd3);
  assign last_word = (out_row == ROW_MAX) && (lane == 2'd3);

  assign oVALID = (buf_cnt != 2'd0);
  assign oDATA  = slot[head][lane];
  assign oINDEX = {out_row, lane};
  assign oLAST  = oVALID && last_word;
  assign oBUSY  = (state != S_IDLE);
  assign oDONE  = done_q;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state    <= S_IDLE;
      tags     <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      buf_cnt  <= 2'd0;
      lane     <= 2'd0;
      out_row  <= '0;
      oADDR_RD <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 4; k++)
          slot[i][k] <= '0;
    end else begin
      done_q <= 1'b0;
      if (iABORT) begin
        state   <= S_IDLE;
        tags    <= '0;
        head    <= 1'b0;
        tail    <= 1'b0;
        buf_cnt <= 2'd0;
        lane    <= 2'd0;
      end else begin
        // Datapath first so the start branch below can override it.
        tags <= (tags << 1) | RD_LAT'(issue);
        if (issue && (oADDR_RD != ROW_MAX))
          oADDR_RD <= oADDR_RD + 1'b1;
        if (capture) begin
          slot[tail][0] <= iBANK_0;
          slot[tail][1] <= iBANK_1;
          slot[tail][2] <= iBANK_2;
          slot[tail][3] <= iBANK_3;
          tail <= ~tail;
        end
        if (hs)
          lane <= lane + 2'd1;
        if (pop) begin
          head <= ~head;
          if (out_row != ROW_MAX)
            out_row <= out_row + 1'b1;
        end
        buf_cnt <= buf_cnt + 2'(capture) - 2'(pop);

        case (state)
          S_IDLE: begin
            if (iSTART) begin
              state    <= S_RUN;
              tags     <= '0;
              head     <= 1'b0;
              tail     <= 1'b0;
              buf_cnt  <= 2'd0;
              lane     <= 2'd0;
              out_row  <= '0;
              oADDR_RD <= '0;
            end
          end
          S_RUN: begin
            if (issue && (oADDR_RD == ROW_MAX))
              state <= S_FLUSH;
          end
          S_FLUSH: begin
            if (hs && last_word) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
